// File: rtl/fptd_razor_ctrl.sv
// Iteration sequencer and Razor error-recovery controller for a chain of
// FPTD decoder sections. Drives the shared Enable for a programmed number of
// error-free iterations. When any section flags a Razor error, it stalls
// the chain for REPLAY cycles and routes the latched flags to neighbouring
// sections so they reload their shadow values. The failed iteration is then
// replayed. A frame aborts with Fail once ERR_MAX errors have been seen.
module fptd_razor_ctrl #(
  parameter int NSEC    = 8,
  parameter int REPLAY  = 2,
  parameter int ERR_MAX = 100
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Start,
  input  logic [7:0]      NumIter,
  input  logic [NSEC-1:0] Error_current_Alpha,
  input  logic [NSEC-1:0] Error_current_Beta,
  input  logic [NSEC-1:0] Error_current_be1,
  output logic            Enable,
  output logic [NSEC-1:0] Error_previous_Alpha,
  output logic [NSEC-1:0] Error_previous_Beta,
  output logic [NSEC-1:0] Error_previous_be1,
  output logic            Busy,
  output logic            Done,
  output logic            Fail,
  output logic [7:0]      IterCount,
  output logic [15:0]     ErrCount
);

  localparam int RW = (REPLAY > 1) ? $clog2(REPLAY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_RECOVER,
    ST_DONE
  } state_t;

  state_t          state, state_next;
  logic [7:0]      num_iter_q, num_iter_next;
  logic [RW-1:0]   replay_cnt, replay_cnt_next;
  logic [7:0]      iter_next;
  logic [15:0]     err_cnt_next;
  logic [15:0]     err_cnt_inc;
  logic            fail_next;
  logic [NSEC-1:0] prev_a_next, prev_b_next, prev_e_next;
  logic            any_err;

  assign any_err     = |{Error_current_Alpha, Error_current_Beta, Error_current_be1};
  assign err_cnt_inc = (ErrCount == 16'hFFFF) ? ErrCount : ErrCount + 16'd1;

  // Next-state and next-value logic for the sequencer and all its counters
  always_comb begin
    state_next      = state;
    num_iter_next   = num_iter_q;
    replay_cnt_next = replay_cnt;
    iter_next       = IterCount;
    err_cnt_next    = ErrCount;
    fail_next       = Fail;
    prev_a_next     = '0;
    prev_b_next     = '0;
    prev_e_next     = '0;

    case (state)
      ST_IDLE: begin
        if (Start) begin
          num_iter_next = (NumIter == 8'd0) ? 8'd1 : NumIter;
          iter_next     = 8'd0;
          err_cnt_next  = 16'd0;
          fail_next     = 1'b0;
          state_next    = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!any_err) begin
          iter_next = IterCount + 8'd1;
          if (iter_next == num_iter_q) state_next = ST_DONE;
        end else begin
          err_cnt_next = err_cnt_inc;
          if (32'(err_cnt_inc) >= 32'(ERR_MAX)) begin
            fail_next  = 1'b1;
            state_next = ST_DONE;
          end else begin
            // Alpha recursion runs forward, beta backward, be1 stays local
            prev_a_next     = {Error_current_Alpha[NSEC-2:0], 1'b0};
            prev_b_next     = {1'b0, Error_current_Beta[NSEC-1:1]};
            prev_e_next     = Error_current_be1;
            replay_cnt_next = RW'(REPLAY - 1);
            state_next      = ST_RECOVER;
          end
        end
      end

      ST_RECOVER: begin
        if (replay_cnt == '0) begin
          state_next = ST_RUN;
        end else begin
          replay_cnt_next = replay_cnt - RW'(1);
          prev_a_next     = Error_previous_Alpha;
          prev_b_next     = Error_previous_Beta;
          prev_e_next     = Error_previous_be1;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, counters and every output are registered so the section array sees clean levels
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state                <= ST_IDLE;
      num_iter_q           <= 8'd1;
      replay_cnt           <= '0;
      IterCount            <= 8'd0;
      ErrCount             <= 16'd0;
      Fail                 <= 1'b0;
      Enable               <= 1'b0;
      Busy                 <= 1'b0;
      Done                 <= 1'b0;
      Error_previous_Alpha <= '0;
      Error_previous_Beta  <= '0;
      Error_previous_be1   <= '0;
    end else begin
      state                <= state_next;
      num_iter_q           <= num_iter_next;
      replay_cnt           <= replay_cnt_next;
      IterCount            <= iter_next;
      ErrCount             <= err_cnt_next;
      Fail                 <= fail_next;
      Enable               <= (state_next == ST_RUN);
      Busy                 <= (state_next == ST_RUN) || (state_next == ST_RECOVER);
      Done                 <= (state_next == ST_DONE);
      Error_previous_Alpha <= prev_a_next;
      Error_previous_Beta  <= prev_b_next;
      Error_previous_be1   <= prev_e_next;
    end
  end

endmodule

// File: doc/fptd_razor_ctrl.md
# fptd_razor_ctrl

Iteration sequencer and Razor error-recovery controller for a chain of NSEC FPTD decoder sections (Section_razor1 instances). Runs a programmed number of fully parallel decoding iterations by driving the shared Enable. It collects the per-section Razor error flags (alpha, beta, be1). On any flagged error it stalls the chain, routes the errors back as Error_previous_* so neighbouring sections reload their shadow values, and replays the failed iteration. Sits between the frame-level decoder top and the section array.

## Interface
- NSEC, 8: number of sections in the chain (≥2)
- REPLAY, 2: stall cycles per recovery (≥1)
- ERR_MAX, 100: errors per frame that abort the frame (1..65535)
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  one-cycle frame start request
- NumIter  in  8  iterations for the frame; 0 treated as 1
- Error_current_Alpha  in  NSEC  per-section alpha Razor flag
- Error_current_Beta  in  NSEC  per-section beta Razor flag
- Error_current_be1  in  NSEC  per-section be1 Razor flag
- Enable  out  1  section-array enable
- Error_previous_Alpha  out  NSEC  routed alpha recovery flags
- Error_previous_Beta  out  NSEC  routed beta recovery flags
- Error_previous_be1  out  NSEC  routed be1 recovery flags
- Busy  out  1  frame in progress
- Done  out  1  one-cycle frame-complete pulse
- Fail  out  1  frame aborted on ERR_MAX; held until next accepted Start
- IterCount  out  8  completed (error-free) iterations
- ErrCount  out  16  errors in current frame, saturating at 16'hFFFF

## Operation
- States: IDLE, RUN, RECOVER, DONE. All outputs are registered. Enable = (state==RUN). Busy = (state==RUN or RECOVER). Done = (state==DONE).
- IDLE: on Start, latch NumIter (0→1), clear IterCount, ErrCount and Fail, then go to RUN. Start is ignored in every other state.
- RUN: each edge samples err = OR of all 3·NSEC error inputs.
  - err=0: IterCount+1. If the new IterCount equals the latched NumIter, go to DONE.
  - err=1: IterCount unchanged, so the iteration is replayed. ErrCount+1.
    - If the new ErrCount ≥ ERR_MAX: set Fail and go to DONE.
    - Otherwise latch the three error vectors, load the replay counter with REPLAY-1, and go to RECOVER.
- RECOVER: Enable=0. Error_previous outputs are driven from the latched vectors:
  - Alpha[k] = latA[k-1]; Alpha[0] = 0 (forward recursion).
  - Beta[k] = latB[k+1]; Beta[NSEC-1] = 0 (backward recursion).
  - be1[k] = latE[k].
  - The counter decrements each cycle. At 0, clear all Error_previous outputs on the same edge and return to RUN.
- DONE: lasts one cycle, then goes to IDLE. Fail stays valid after DONE.
- Error inputs are ignored outside RUN.
- Error_previous_* are 0 in every state except RECOVER.

## Timing
- Reset (async, immediate): state IDLE. Enable, Busy, Done and Fail are 0. IterCount, ErrCount and all Error_previous_* are 0.
- Start sampled at edge t: Enable=1 from t to t+1.
- Error-free frame: Enable high for exactly NumIter cycles, then Done high for one cycle. Start-to-Done latency is NumIter+1 edges.
- Each recovered error adds 1+REPLAY cycles: the errored Enable cycle plus REPLAY stall cycles.
- Error_previous_* are asserted for exactly REPLAY cycles, coincident with Enable=0.
- An error on the final iteration is replayed; Done is not issued until an error-free final cycle.
- Abort: the edge that brings ErrCount to ERR_MAX moves the FSM to DONE. Done and Fail rise together the next cycle, with no RECOVER.
- Reset during RUN or RECOVER aborts immediately with no Done pulse. Error_previous_* clear asynchronously.
- Start coincident with Reset is ignored.

## Test plan
- Reset, then Start with NumIter=5 and no errors: Enable high for 5 cycles, Done pulse on the 6th cycle, IterCount=5, ErrCount=0, Fail=0.
- NumIter=4 with Error_current_Alpha=8'b0000_0100 during the 2nd Enable cycle, NSEC=8, REPLAY=2:
  - Enable pattern 1,1,0,0,1,1,1 (Enable low for 2 cycles).
  - Error_previous_Alpha=8'b0000_1000 for those 2 cycles.
  - Done after 5 high Enable cycles, ErrCount=1.
- Error_current_Beta=8'b0000_0001 plus Error_current_be1=8'b1000_0000 in the same cycle:
  - Error_previous_Beta=0 (k=0 has no k+1 source; bit 0 routes nowhere).
  - Error_previous_be1=8'b1000_0000.
  - Error_current_Alpha bit 7 → Error_previous_Alpha bit 0 stays 0.
- ERR_MAX=3 with errors held constantly high: ErrCount reaches 3, Done and Fail go to 1 together, IterCount=0, Fail holds until the next Start.
- NumIter=0: behaves as 1, with exactly one Enable cycle then Done.
- Start pulsed during RUN is ignored. Reset asserted mid-RECOVER: all outputs go to 0 at once, with no Done; a fresh Start afterwards runs normally.
